// File: rtl/panel_io_core_if.sv
// ---------------------------------------------------------------------------
// panel_io_core_if
// Bundles the front-panel key and display signals that pass between the
// panel core and the board logic that uses it.
//   key             5  raw keys, active-low (UP, DOWN, LEFT, RIGHT, ENTER)
//   number         20  binary value to display
//   point_position  6  decimal-point mask, bit i = digit i
//   shank_position  6  blink mask, bit i = digit i
//   key_state      10  [4:0] debounced levels, [9:5] one-clk press pulses
//   dig             8  segments, active-low, [7] = dp
//   sel             6  digit select, active-low, sel[0] = rightmost digit
// master: the board side (drives keys and display data).
// slave:  the panel core.
// ---------------------------------------------------------------------------
interface panel_io_core_if;
    logic [4:0]  key;
    logic [19:0] number;
    logic [5:0]  point_position;
    logic [5:0]  shank_position;
    logic [9:0]  key_state;
    logic [7:0]  dig;
    logic [5:0]  sel;

    modport master (
        output key, number, point_position, shank_position,
        input  key_state, dig, sel
    );

    modport slave (
        input  key, number, point_position, shank_position,
        output key_state, dig, sel
    );
endinterface

// File: rtl/panel_io_core.sv
// ---------------------------------------------------------------------------
// panel_io_core
// Front-panel I/O for the signal-generator board: timebases, uptime
// counters, debounced navigation keys and a 6-digit multiplexed 7-segment
// display of a 20-bit value in decimal. Single clock domain; the divided
// clocks are outputs only.
// Ports:
//   clk               system clock (50 MHz)
//   rst_n             synchronous active-low reset
//   io                panel_io_core_if.slave (keys, display data, key_state,
//                     dig, sel)
//   clk_100k          100 kHz square wave, 50% duty
//   clk_1k            1 kHz square wave, 50% duty
//   tick_1k           one-clk strobe every SLOW_DIV cycles
//   system_time       ms since reset (wraps)
//   system_time_10ms  10 ms units since reset (wraps)
// ---------------------------------------------------------------------------
module panel_io_core #(
    parameter int FAST_DIV    = 500,
    parameter int SLOW_DIV    = 50000,
    parameter int DEBOUNCE_MS = 20,
    parameter int BLINK_MS    = 250
) (
    input  logic                 clk,
    input  logic                 rst_n,
    panel_io_core_if.slave       io,
    output logic                 clk_100k,
    output logic                 clk_1k,
    output logic                 tick_1k,
    output logic [31:0]          system_time,
    output logic [31:0]          system_time_10ms
);

    localparam int FAST_HALF = FAST_DIV / 2;
    localparam int FW        = $clog2(FAST_HALF);
    localparam int SW        = $clog2(SLOW_DIV);
    localparam int DW        = $clog2(DEBOUNCE_MS + 1);
    localparam int BW        = $clog2(BLINK_MS + 1);

    // ------------------------------------------------------------------
    // Timebases and uptime counters
    // ------------------------------------------------------------------
    logic [FW-1:0] fast_cnt;
    logic [SW-1:0] slow_cnt;
    logic [3:0]    tenth_cnt;
    logic          slow_mid;
    logic          slow_wrap;

    assign slow_mid  = (slow_cnt == SW'(SLOW_DIV / 2 - 1));
    assign slow_wrap = (slow_cnt == SW'(SLOW_DIV - 1));

    // NOTE: every register here is written with <= so that all flops sample
    // the same pre-edge values; blocking = would make results depend on
    // statement order within the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fast_cnt <= '0;
            clk_100k <= 1'b0;
        end else if (fast_cnt == FW'(FAST_HALF - 1)) begin
            fast_cnt <= '0;
            clk_100k <= ~clk_100k;
        end else begin
            fast_cnt <= fast_cnt + FW'(1);
        end
    end

    // clk_1k rises half-way through the slow period and falls at its end,
    // together with the tick strobe and the uptime increments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slow_cnt         <= '0;
            clk_1k           <= 1'b0;
            tick_1k          <= 1'b0;
            tenth_cnt        <= '0;
            system_time      <= '0;
            system_time_10ms <= '0;
        end else begin
            tick_1k <= slow_wrap;
            if (slow_wrap) begin
                slow_cnt    <= '0;
                clk_1k      <= 1'b0;
                system_time <= system_time + 32'd1;
                if (tenth_cnt == 4'd9) begin
                    tenth_cnt        <= '0;
                    system_time_10ms <= system_time_10ms + 32'd1;
                end else begin
                    tenth_cnt <= tenth_cnt + 4'd1;
                end
            end else begin
                slow_cnt <= slow_cnt + SW'(1);
                if (slow_mid) clk_1k <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Key synchroniser and debouncer
    // ------------------------------------------------------------------
    logic [4:0]    key_meta;
    logic [4:0]    key_sync;
    logic [4:0]    key_pressed;
    logic [4:0]    key_level;
    logic [4:0]    key_pulse;
    logic [DW-1:0] db_cnt [5];

    // Synchroniser resets to all-ones (keys released) so no phantom press
    // is seen while the raw inputs settle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_meta <= 5'h1F;
            key_sync <= 5'h1F;
        end else begin
            key_meta <= io.key;
            key_sync <= key_meta;
        end
    end

    assign key_pressed = ~key_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_level <= '0;
            key_pulse <= '0;
            // NOTE: db_cnt is five small counters, not a RAM, so clearing
            // it in reset is cheap and keeps a mid-run reset deterministic.
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            key_pulse <= '0;
            if (tick_1k) begin
                for (int i = 0; i < 5; i++) begin
                    if (key_pressed[i] == key_level[i]) begin
                        db_cnt[i] <= '0;
                    end else if (db_cnt[i] == DW'(DEBOUNCE_MS - 1)) begin
                        // This is the DEBOUNCE_MS-th differing sample.
                        db_cnt[i]    <= '0;
                        key_level[i] <= ~key_level[i];
                        key_pulse[i] <= ~key_level[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end
            end
        end
    end

    assign io.key_state = {key_pulse, key_level};

    // ------------------------------------------------------------------
    // Binary to BCD (sequential double-dabble, one bit per clk)
    // ------------------------------------------------------------------
    logic [19:0] number_sat;
    logic [19:0] conv_bin;
    logic [22:0] conv_bcd;
    logic [22:0] bcd_adj;
    logic [23:0] bcd_next;
    logic [4:0]  conv_cnt;
    logic        conv_busy;
    logic [23:0] disp_bcd;

    assign number_sat = (io.number > 20'd999999) ? 20'd999999 : io.number;

    // The top digit never exceeds 4 before the final shift (result <= 9),
    // so only digits 0..4 need the add-3 step and the working register
    // can stay 23 bits wide.
    // NOTE: bcd_adj gets a full default before the conditional updates so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        bcd_adj = conv_bcd;
        for (int i = 0; i < 5; i++) begin
            if (conv_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = conv_bcd[4*i +: 4] + 4'd3;
        end
        bcd_next = {bcd_adj, conv_bin[19]};
    end

    // A new tick restarts the conversion; with the 1 ms tick the 20-clk
    // conversion always finishes long before that.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conv_bin  <= '0;
            conv_bcd  <= '0;
            conv_cnt  <= '0;
            conv_busy <= 1'b0;
            disp_bcd  <= '0;
        end else if (tick_1k) begin
            conv_bin  <= number_sat;
            conv_bcd  <= '0;
            conv_cnt  <= '0;
            conv_busy <= 1'b1;
        end else if (conv_busy) begin
            conv_bin <= {conv_bin[18:0], 1'b0};
            conv_bcd <= bcd_next[22:0];
            if (conv_cnt == 5'd19) begin
                conv_busy <= 1'b0;
                disp_bcd  <= bcd_next;
            end else begin
                conv_cnt <= conv_cnt + 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan and blink
    // ------------------------------------------------------------------
    logic [2:0]    scan_idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_blank;
    logic [3:0]    cur_digit;
    logic [7:0]    seg;
    logic [7:0]    dig_q;
    logic [5:0]    sel_q;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    assign cur_digit = disp_bcd[{scan_idx, 2'b00} +: 4];

    always_comb begin
        seg = seg_code(cur_digit);
        if (io.point_position[scan_idx]) seg[7] = 1'b0;
        if (io.shank_position[scan_idx] && blink_blank) seg = 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_idx    <= '0;
            blink_cnt   <= '0;
            blink_blank <= 1'b0;
            dig_q       <= 8'hFF;
            sel_q       <= 6'h3F;
        end else if (tick_1k) begin
            dig_q    <= seg;
            sel_q    <= ~(6'b1 << scan_idx);
            scan_idx <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
            if (blink_cnt == BW'(BLINK_MS - 1)) begin
                blink_cnt   <= '0;
                blink_blank <= ~blink_blank;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

    assign io.dig = dig_q;
    assign io.sel = sel_q;

endmodule

// File: tb/tb_panel_io_core.sv
// ---------------------------------------------------------------------------
// tb_panel_io_core
// Self-checking bench for panel_io_core with short divisors
// (FAST_DIV=10, SLOW_DIV=50, DEBOUNCE_MS=20, BLINK_MS=4).
// ---------------------------------------------------------------------------
module tb_panel_io_core;

    localparam int FAST_DIV    = 10;
    localparam int SLOW_DIV    = 50;
    localparam int DEBOUNCE_MS = 20;
    localparam int BLINK_MS    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_100k;
    logic        clk_1k;
    logic        tick_1k;
    logic [31:0] system_time;
    logic [31:0] system_time_10ms;

    panel_io_core_if io ();

    panel_io_core #(
        .FAST_DIV(FAST_DIV), .SLOW_DIV(SLOW_DIV),
        .DEBOUNCE_MS(DEBOUNCE_MS), .BLINK_MS(BLINK_MS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .io(io.slave),
        .clk_100k(clk_100k), .clk_1k(clk_1k), .tick_1k(tick_1k),
        .system_time(system_time), .system_time_10ms(system_time_10ms)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int tick_no = 0;
    int pulse_cnt [5] = '{default: 0};

    // Ticks since reset release; the scan step for tick k shows digit (k-1)%6.
    always @(negedge clk) begin
        if (!rst_n) tick_no <= 0;
        else if (tick_1k) tick_no <= tick_no + 1;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) pulse_cnt[i] <= pulse_cnt[i] + int'(io.key_state[5+i]);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!tick_1k && n < 200);
        if (!tick_1k) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got no tick in %0d cycles want tick", n);
        end
    endtask

    // One scan/debounce step: the edge after the tick strobe.
    task automatic step();
        wait_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dig"},   io.dig, 8'hFF);
        check({tag, "_sel"},   io.sel, 6'h3F);
        check({tag, "_keys"},  io.key_state, 10'h0);
        check({tag, "_time"},  system_time, 32'd0);
        check({tag, "_time10"}, system_time_10ms, 32'd0);
        check({tag, "_clk1k"}, clk_1k, 1'b0);
        check({tag, "_clk100k"}, clk_100k, 1'b0);
        check({tag, "_tick"},  tick_1k, 1'b0);
    endtask

    typedef struct {
        logic [19:0]     number;
        logic [5:0]      point;
        logic [5:0]      shank;
        logic [5:0][7:0] seg;     // visible-phase code, [0] = rightmost digit
        int              steps;
    } vec_t;

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] dig;
    } scan_t;

    vec_t  vecs [9];
    scan_t sb_q [$];

    initial begin
        int   first_rise_1k, tick_a, tick_b, rise_a, rise_b;
        logic prev_1k, prev_100k;
        bit   k0_seen;
        int   k, d;
        scan_t exp_s, got_s;

        vecs[0] = '{20'd123456,  6'b000100, 6'b000000, {8'hF9, 8'hA4, 8'hB0, 8'h19, 8'h92, 8'h82}, 12};
        vecs[1] = '{20'hFFFFF,   6'b000000, 6'b000000, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}, 12};
        vecs[2] = '{20'd7,       6'b000000, 6'b000001, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF8}, 24};
        vecs[3] = '{20'd999999,  6'b100001, 6'b000000, {8'h10, 8'h90, 8'h90, 8'h90, 8'h90, 8'h10}, 12};
        vecs[4] = '{20'd0,       6'b111111, 6'b000000, {8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40}, 12};
        vecs[5] = '{20'd1000000, 6'b000000, 6'b000000, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}, 12};
        vecs[6] = '{20'd100005,  6'b000000, 6'b000000, {8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h92}, 12};
        vecs[7] = '{20'd999999,  6'b000000, 6'b111111, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}, 12};
        vecs[8] = '{20'd86,      6'b000000, 6'b000000, {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h80, 8'h82}, 12};

        io.key = 5'h1F;
        io.number = '0;
        io.point_position = '0;
        io.shank_position = '0;

        // ---- reset and timebase ----
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        #1 rst_n = 1'b1;

        first_rise_1k = -1; tick_a = -1; tick_b = -1; rise_a = -1; rise_b = -1;
        prev_1k = 1'b0; prev_100k = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk);
            #1;
            if (clk_1k && !prev_1k && first_rise_1k < 0) first_rise_1k = n;
            if (clk_100k && !prev_100k) begin
                if (rise_a < 0) rise_a = n;
                else if (rise_b < 0) rise_b = n;
            end
            if (tick_1k) begin
                if (tick_a < 0) tick_a = n;
                else if (tick_b < 0) tick_b = n;
            end
            prev_1k = clk_1k;
            prev_100k = clk_100k;
        end
        check("clk_1k_first_rise", first_rise_1k, 25);
        check("tick_first",        tick_a, 50);
        check("tick_second",       tick_b, 100);
        check("clk_100k_period",   rise_b - rise_a, 10);
        check("system_time_1000",  system_time, 32'd20);
        check("system_time10_1000", system_time_10ms, 32'd2);

        // ---- clean simultaneous press on UP? no: DOWN, RIGHT, ENTER ----
        step();
        io.key = 5'b00101;  // keys 1, 3, 4 pressed
        for (int t = 1; t <= DEBOUNCE_MS; t++) begin
            step();
            if (t == DEBOUNCE_MS - 1) check("press_before_20", io.key_state, 10'h0);
            if (t == DEBOUNCE_MS)     check("press_at_20", io.key_state, {5'b11010, 5'b11010});
        end
        @(posedge clk);
        #1;
        check("press_pulse_one_clk", io.key_state, {5'b00000, 5'b11010});

        io.key = 5'h1F;
        for (int t = 1; t <= DEBOUNCE_MS; t++) begin
            step();
            if (t == DEBOUNCE_MS - 1) check("release_before_20", io.key_state, {5'b00000, 5'b11010});
            if (t == DEBOUNCE_MS)     check("release_at_20", io.key_state, 10'h0);
        end
        @(negedge clk);
        #1;
        check("pulses_enter", pulse_cnt[4], 1);
        check("pulses_down",  pulse_cnt[1], 1);

        // ---- bouncing UP: toggles every 5 ticks, never accepted ----
        k0_seen = 1'b0;
        io.key[0] = 1'b0;
        for (int t = 1; t <= 100; t++) begin
            step();
            if (io.key_state[0]) k0_seen = 1'b1;
            if (t % 5 == 0) io.key[0] = ~io.key[0];
        end
        io.key[0] = 1'b1;
        repeat (3) step();
        check("bounce_level_never", k0_seen, 1'b0);
        check("bounce_no_pulse",    pulse_cnt[0], 0);

        // ---- display vectors with scoreboard ----
        for (int v = 0; v < 9; v++) begin
            io.number = vecs[v].number;
            io.point_position = vecs[v].point;
            io.shank_position = vecs[v].shank;
            wait_tick();  // this tick latches the new number
            for (int s = 0; s < vecs[v].steps; s++) begin
                wait_tick();
                @(negedge clk);
                #1;
                k = tick_no;
                d = (k - 1) % 6;
                exp_s.sel = ~(6'b1 << d);
                exp_s.dig = (vecs[v].shank[d] && (((k - 1) / BLINK_MS) % 2 == 1))
                            ? 8'hFF : vecs[v].seg[d];
                sb_q.push_back(exp_s);
                @(posedge clk);
                #1;
                got_s.sel = io.sel;
                got_s.dig = io.dig;
                exp_s = sb_q.pop_front();
                check($sformatf("vec%0d_step%0d_sel", v, s), got_s.sel, exp_s.sel);
                check($sformatf("vec%0d_step%0d_dig", v, s), got_s.dig, exp_s.dig);
            end
        end
        io.point_position = '0;
        io.shank_position = '0;

        // ---- mid-run reset with a key held ----
        io.key = 5'b11011;
        for (int t = 1; t <= DEBOUNCE_MS + 1; t++) step();
        check("held_key_accepted", io.key_state[2], 1'b1);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("midrun");
        #1 rst_n = 1'b1;
        io.key = 5'h1F;
        repeat (60) @(posedge clk);
        #1;
        check("after_reset_time", system_time, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
